mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Sequential multiply/divide unit in the E stage of the pipelined MIPS core. It is the responder to the instruction decoder's `start`, mult/div and mthi/mtlo controls. It holds the architectural HI/LO registers and runs a fixed-latency multiply or divide. It reports `busy` so the hazard unit can stall mfhi/mflo and any further HI/LO instruction.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu
- DIV_CYCLES, 10, busy duration of div/divu

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  decoder start, valid only with a mult/multu/div/divu op
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- req  input  1  exception/interrupt flush of the instruction currently in E
- A  input  32  forwarded rs value
- B  input  32  forwarded rt value
- busy  output  1  registered; high while an operation is in flight
- HI  output  32  registered HI register
- LO  output  32  registered LO register

## Operation
- Reset: busy=0, HI=0, LO=0, counter=0, and the operand/op latches are cleared.
- States:
  - IDLE (counter==0, busy=0)
  - RUN (counter>0, busy=1)
- IDLE → RUN at an edge with start=1, md_op∈{1..4}, req=0:
  - latch A, B and the op
  - counter = MULT_CYCLES or DIV_CYCLES
  - busy=1
- RUN: each edge decrements the counter.
  - At the edge where counter==1, HI/LO are written with the result, counter=0, busy=0.
- Results:
  - mult: {HI,LO} = $signed(A)*$signed(B), full 64-bit.
  - multu: {HI,LO} = A*B unsigned, 64-bit.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: LO = A/B, HI = A%B unsigned.
  - Division by zero (B==0, div or divu): the operation still takes DIV_CYCLES, and HI/LO are left unchanged.
- mthi/mtlo:
  - at an edge with md_op=5 (or 6), req=0 and busy=0: HI (or LO) = A
  - takes one cycle and never sets busy
- req=1 squashes start and mthi/mtlo in the same cycle; no state changes.
- req does not abort an operation already in RUN, because that instruction has already left E.
- start or mthi/mtlo while busy=1 is ignored. The hazard unit prevents this; the unit must not corrupt state if it occurs.
- start=1 with md_op∉{1..4} is ignored.
- HI/LO change only at:
  - completion of an operation
  - a mthi/mtlo write
  - reset

## Timing
- Start accepted at edge E0; busy=1 from E0 through the cycle before edge E0+N (N = MULT_CYCLES or DIV_CYCLES).
- At edge E0+N, HI/LO take the new values and busy falls. busy is therefore high for exactly N cycles.
- A new start is accepted at edge E0+N+1 at the earliest. Back-to-back operations with no idle gap are not required.
- Operands are sampled only at E0. Later changes on A/B have no effect.
- mthi/mtlo: the value is visible on HI/LO one cycle after the write edge.
- The hazard unit stalls mfhi/mflo/mthi/mtlo/mult/div in D while (start_E | busy). start_E is combinational from the E-stage decoder; this unit does not provide it.
- Reset has priority over every input. Reset mid-RUN discards the pending result, and HI/LO read 0 after the reset edge.

## Test plan
- **Signed mult:** after reset, start, md_op=1, A=0xFFFFFFFE (-2), B=3.
  - busy high for 5 cycles.
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged while busy.
- **Unsigned mult:** md_op=2, A=0xFFFFFFFF, B=0xFFFFFFFF.
  - after 5 cycles, HI=0xFFFFFFFE, LO=0x00000001.
- **Signed and unsigned div:**
  - md_op=3, A=-7 (0xFFFFFFF9), B=2: busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - md_op=4, same operands: LO=0x7FFFFFFC, HI=1.
  - overflow case md_op=3, A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- **Divide by zero and reset mid-run:**
  - preload HI=0x11, LO=0x22 via mthi/mtlo; div with B=0: after 10 cycles, HI=0x11, LO=0x22.
  - start mult 3*4 then assert reset on cycle 2 of busy: busy=0, HI=LO=0, and no write follows.
- **req squash:**
  - start, md_op=1 with req=1: busy stays 0, HI/LO unchanged.
  - mtlo A=0x55 with req=1: LO unchanged.
  - req asserted during an accepted RUN: the result is still written at cycle N.
- **Ignored while busy:** during a div, drive mthi A=0xABCD and a second start.
  - both are ignored.
  - the final HI/LO match the first div only, and busy lasts exactly 10 cycles.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Decoder <-> multiply/divide unit signal bundle.
// master: E-stage decoder side, slave: the mul/div unit itself.
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic        req;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, req, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, md_op, req, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// Fixed-latency multiply/divide unit holding the architectural HI/LO pair.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no operation in flight; accepts start, mthi, mtlo
// S_RUN  | operation in flight; counter runs down, result lands at 1
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mul_div_unit_if.slave  md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;
    logic               is_md_start;

    // Result datapath, evaluated from the latched operands. Signed divide
    // works on magnitudes so INT_MIN / -1 wraps to INT_MIN with no trap.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_mag  = (op_q == OP_DIV && a_q[31]) ? (32'd0 - a_q) : a_q;
        b_mag  = (op_q == OP_DIV && b_q[31]) ? (32'd0 - b_q) : b_q;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b0;
        case (op_q)
            OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
                res_wr = 1'b1;
            end
            OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
                res_wr = 1'b1;
            end
            OP_DIV: begin
                res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = a_q[31] ? (32'd0 - r_mag) : r_mag;
                res_wr = (b_q != 32'd0);
            end
            OP_DIVU: begin
                res_lo = q_mag;
                res_hi = r_mag;
                res_wr = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    assign is_md_start = md.start && (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);

    // Next-state: accept work only when idle and not flushed; count down while running.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (!md.req) begin
                    if (is_md_start) begin
                        op_d    = md.md_op;
                        a_d     = md.A;
                        b_d     = md.B;
                        cnt_d   = (md.md_op == OP_MULT || md.md_op == OP_MULTU)
                                  ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d = S_RUN;
                    end else if (md.md_op == OP_MTHI) begin
                        hi_d = md.A;
                    end else if (md.md_op == OP_MTLO) begin
                        lo_d = md.A;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    op_d    = OP_NONE;
                    if (res_wr) begin
                        hi_d = res_hi;
                        lo_d = res_lo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, operand latches and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign md.busy = (state_q == S_RUN);
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases with literal
// expectations plus a randomized run against a cycle-level reference model.
module tb_mul_div_unit;

    localparam int NM = 5;
    localparam int ND = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;

    mul_div_unit_if mif();

    mul_div_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_left = 0;
    logic [31:0] m_hi = 0, m_lo = 0;
    logic [31:0] p_hi = 0, p_lo = 0;
    bit          p_wr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output bit wr, output logic [31:0] h, output logic [31:0] l);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        wr = 1'b1;
        h  = 32'd0;
        l  = 32'd0;
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                {h, l} = sp;
            end
            3'd2: begin
                up = {32'd0, a} * {32'd0, b};
                {h, l} = up;
            end
            3'd3: begin
                if (b == 32'd0) wr = 1'b0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000;
                    h = 32'd0;
                end else begin
                    sa = a;
                    sb = b;
                    l = sa / sb;
                    h = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) wr = 1'b0;
                else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endtask

    // Model update at each rising edge from the same inputs the DUT sees.
    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_hi   = 0;
            m_lo   = 0;
            p_wr   = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (!mif.req) begin
            if (mif.start && mif.md_op >= 3'd1 && mif.md_op <= 3'd4) begin
                calc(mif.md_op, mif.A, mif.B, p_wr, p_hi, p_lo);
                m_left = (mif.md_op <= 3'd2) ? NM : ND;
            end else if (mif.md_op == 3'd5) begin
                m_hi = mif.A;
            end else if (mif.md_op == 3'd6) begin
                m_lo = mif.A;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, mif.busy}, {31'd0, (m_left > 0)});
            chk("HI", mif.HI, m_hi);
            chk("LO", mif.LO, m_lo);
        end
    end

    task automatic step(input logic st, input logic [2:0] op, input logic rq,
                        input logic [31:0] a, input logic [31:0] b);
        mif.start = st;
        mif.md_op = op;
        mif.req   = rq;
        mif.A     = a;
        mif.B     = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 32'd0, 32'd0);
    endtask

    // mode 0: quiet; 1: mthi + second start while busy; 2: req held while busy
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int mode, input int exp_n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        logic [31:0] hi0, lo0;
        hi0 = mif.HI;
        lo0 = mif.LO;
        step(1'b1, op, 1'b0, a, b);
        n = 0;
        while (mif.busy && n < 40) begin
            if (n == 1) begin
                chk({name, "_hi_hold"}, mif.HI, hi0);
                chk({name, "_lo_hold"}, mif.LO, lo0);
            end
            if (mode == 1 && n == 0)      step(1'b0, 3'd5, 1'b0, 32'hABCD, 32'd0);
            else if (mode == 1 && n == 1) step(1'b1, 3'd1, 1'b0, 32'd9, 32'd9);
            else if (mode == 2)           step(1'b0, 3'd0, 1'b1, 32'd0, 32'd0);
            else                          step(1'b0, 3'd0, 1'b0, $urandom, $urandom);
            n++;
        end
        chk({name, "_cycles"}, n, exp_n);
        chk({name, "_HI"}, mif.HI, exp_hi);
        chk({name, "_LO"}, mif.LO, exp_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset     = 1'b1;
        mif.start = 1'b0;
        mif.md_op = 3'd0;
        mif.req   = 1'b0;
        mif.A     = 32'd0;
        mif.B     = 32'd0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, mif.busy}, 32'd0);
        chk("rst_HI", mif.HI, 32'd0);
        chk("rst_LO", mif.LO, 32'd0);
        reset = 1'b0;
        idle(1);

        run_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 0, NM, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, NM, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 0, ND, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd4, 32'hFFFF_FFF9, 32'd2, 0, ND, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, ND, 32'd0, 32'h8000_0000);

        step(1'b0, 3'd5, 1'b0, 32'h11, 32'd0);
        step(1'b0, 3'd6, 1'b0, 32'h22, 32'd0);
        chk("mthi", mif.HI, 32'h11);
        chk("mtlo", mif.LO, 32'h22);
        run_op("div0",  3'd3, 32'd1234, 32'd0, 0, ND, 32'h11, 32'h22);
        run_op("divu0", 3'd4, 32'd1234, 32'd0, 0, ND, 32'h11, 32'h22);

        step(1'b1, 3'd1, 1'b0, 32'd3, 32'd4);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("rstrun_busy", {31'd0, mif.busy}, 32'd0);
        chk("rstrun_HI", mif.HI, 32'd0);
        chk("rstrun_LO", mif.LO, 32'd0);
        idle(8);
        chk("rstrun_HI_late", mif.HI, 32'd0);
        chk("rstrun_LO_late", mif.LO, 32'd0);

        step(1'b1, 3'd1, 1'b1, 32'd5, 32'd7);
        chk("req_start_busy", {31'd0, mif.busy}, 32'd0);
        step(1'b0, 3'd6, 1'b0, 32'h99, 32'd0);
        step(1'b0, 3'd6, 1'b1, 32'h55, 32'd0);
        chk("req_mtlo", mif.LO, 32'h99);
        run_op("req_run", 3'd1, 32'd6, 32'd7, 2, NM, 32'd0, 32'd42);

        run_op("busy_ign", 3'd3, 32'd100, 32'd7, 1, ND, 32'd2, 32'd14);
        idle(NM + 2);
        chk("busy_ign_HI_after", mif.HI, 32'd2);
        chk("busy_ign_LO_after", mif.LO, 32'd14);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 99) < 25, 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) == 0, pick(), pick());
        end
        reset = 1'b0;
        idle(ND + 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
